// File: rtl/lfsr_msg_decoder.sv
// LFSR message decryptor: recovers tap pattern and seed from the space preamble,
// then streams the 64-byte block out of DM, strips leading spaces and pads the tail.
module lfsr_msg_decoder #(
  parameter int CRYPT_BASE = 64,
  parameter int PLAIN_BASE = 0,
  parameter int MIN_PRE    = 10
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [7:0] dm_raddr,
  input  logic [7:0] dm_rdata,
  output logic       dm_we,
  output logic [7:0] dm_waddr,
  output logic [7:0] dm_wdata,
  output logic [3:0] tap_idx,
  output logic [6:0] seed,
  output logic       fail,
  output logic [6:0] par_err_cnt
);

  typedef enum logic [2:0] {IDLE, SEED, SEARCH, DECODE, PAD, DONE} state_t;

  state_t     state, state_nx;
  logic [6:0] i, w, s;
  logic [3:0] p, k;
  logic       dvld;
  logic [6:0] pre_buf [MIN_PRE];

  logic [6:0] tap_sel, s_nx, exp_k;
  logic       hit, last_k, par_bad, keep;
  logic [7:0] dec_byte;

  function automatic logic [6:0] tap_of(input logic [3:0] x);
    case (x)
      4'd0:    tap_of = 7'h60;
      4'd1:    tap_of = 7'h48;
      4'd2:    tap_of = 7'h78;
      4'd3:    tap_of = 7'h72;
      4'd4:    tap_of = 7'h6A;
      4'd5:    tap_of = 7'h69;
      4'd6:    tap_of = 7'h5C;
      4'd7:    tap_of = 7'h7E;
      4'd8:    tap_of = 7'h7B;
      default: tap_of = 7'h00;
    endcase
  endfunction

  // One LFSR stepper shared by the search (candidate p) and decode (recovered tap)
  always_comb begin
    tap_sel = (state == SEARCH) ? tap_of(p) : tap_of(tap_idx);
    s_nx    = {s[5:0], ^(s & tap_sel)};
    exp_k   = '0;
    for (int j = 0; j < MIN_PRE; j++)
      if (k == 4'(j)) exp_k = pre_buf[j] ^ 7'h20;
    hit      = (s_nx == exp_k);
    last_k   = (k == 4'(MIN_PRE - 1));
    par_bad  = dm_rdata[7] != ^dm_rdata[6:0];
    dec_byte = par_bad ? 8'h80 : {1'b0, dm_rdata[6:0] ^ s};
    keep     = dvld && !(w == 7'd0 && dec_byte == 8'h20);
  end

  always_ff @(posedge clk) begin
    if (!init) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    dm_raddr = '0;
    case (state)
      IDLE:   if (!req) state_nx = SEED;
      SEED: begin
        dm_raddr = 8'(CRYPT_BASE) + {1'b0, i};
        if (i == 7'(MIN_PRE)) state_nx = SEARCH;
      end
      SEARCH: begin
        if (!hit && p == 4'd8)  state_nx = DONE;
        else if (hit && last_k) state_nx = DECODE;
      end
      DECODE: begin
        if (i < 7'd64) dm_raddr = 8'(CRYPT_BASE) + {1'b0, i};
        if (i == 7'd64) state_nx = PAD;
      end
      PAD:    if (w >= 7'd63) state_nx = DONE;
      DONE: begin
        ack = 1'b1;
        if (req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      dm_we       <= 1'b0;
      dm_waddr    <= '0;
      dm_wdata    <= '0;
      tap_idx     <= 4'hF;
      seed        <= '0;
      fail        <= 1'b0;
      par_err_cnt <= '0;
      i           <= '0;
      w           <= '0;
      s           <= '0;
      p           <= '0;
      k           <= '0;
      dvld        <= 1'b0;
      for (int j = 0; j < MIN_PRE; j++) pre_buf[j] <= '0;
    end else begin
      dm_we <= 1'b0;
      dvld  <= 1'b0;
      case (state)
        IDLE: if (!req) begin
          i           <= '0;
          w           <= '0;
          tap_idx     <= 4'hF;
          fail        <= 1'b0;
          par_err_cnt <= '0;
        end
        SEED: begin
          // data for address i-1 lands while address i is presented
          for (int j = 0; j < MIN_PRE; j++)
            if (i == 7'(j + 1)) pre_buf[j] <= dm_rdata[6:0];
          if (i == 7'd1) seed <= dm_rdata[6:0] ^ 7'h20;
          if (i == 7'(MIN_PRE)) begin
            i <= '0;
            p <= '0;
            k <= 4'd1;
            s <= seed;
          end else begin
            i <= i + 7'd1;
          end
        end
        SEARCH: begin
          if (hit) begin
            if (last_k) begin
              tap_idx <= p;
              s       <= seed;
            end else begin
              s <= s_nx;
              k <= k + 4'd1;
            end
          end else begin
            if (p == 4'd8) fail <= 1'b1;
            p <= p + 4'd1;
            k <= 4'd1;
            s <= seed;
          end
        end
        DECODE: begin
          if (i < 7'd64) begin
            i    <= i + 7'd1;
            dvld <= 1'b1;
          end
          if (dvld) begin
            s <= s_nx;
            if (par_bad) par_err_cnt <= par_err_cnt + 7'd1;
            if (keep) begin
              dm_we    <= 1'b1;
              dm_waddr <= 8'(PLAIN_BASE) + {1'b0, w};
              dm_wdata <= dec_byte;
              w        <= w + 7'd1;
            end
          end
        end
        PAD: if (w < 7'd64) begin
          dm_we    <= 1'b1;
          dm_waddr <= 8'(PLAIN_BASE) + {1'b0, w};
          dm_wdata <= 8'h20;
          w        <= w + 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_msg_decoder.sv
// Directed bench for lfsr_msg_decoder: encrypts known plaintexts, predicts the
// recovered key and write stream with a behavioural model, checks every DM write.
module tb_lfsr_msg_decoder;

  localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                      7'h69, 7'h5C, 7'h7E, 7'h7B};

  logic       clk = 1'b0;
  logic       init, req, ack, dm_we, fail;
  logic [7:0] dm_raddr, dm_rdata, dm_waddr, dm_wdata;
  logic [3:0] tap_idx;
  logic [6:0] seed, par_err_cnt;

  always #5 clk = ~clk;

  lfsr_msg_decoder dut (
    .clk(clk), .init(init), .req(req), .ack(ack),
    .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata),
    .tap_idx(tap_idx), .seed(seed), .fail(fail), .par_err_cnt(par_err_cnt)
  );

  // DM: cipher region 64..127, plaintext region 0..63
  logic [7:0] cmem [64];
  logic [7:0] pmem [64];
  always @(posedge clk) dm_rdata <= dm_raddr[6] ? cmem[dm_raddr[5:0]] : pmem[dm_raddr[5:0]];
  always @(posedge clk) if (dm_we && dm_waddr < 8'd64) pmem[dm_waddr[5:0]] <= dm_wdata;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] lstep(input logic [6:0] s, input logic [6:0] p);
    return {s[5:0], ^(s & p)};
  endfunction

  // model outputs
  logic [15:0] wq [$];
  logic [7:0]  m_mem [64];
  logic [7:0]  lit [64];
  logic [3:0]  m_tap;
  logic [6:0]  m_seed, m_par;
  logic        m_fail;

  // encrypt plaintext = pre spaces + message + trailing spaces
  task automatic build(input string m, input int pre, input logic [6:0] sd, input int pi);
    logic [6:0] s, c7;
    logic [7:0] pl;
    int nm;
    s = sd;
    for (int i = 0; i < 64; i++) begin
      pl = (i >= pre && i - pre < m.len()) ? m[i - pre] : 8'h20;
      c7 = pl[6:0] ^ s;
      cmem[i] = {^c7, c7};
      s = lstep(s, TAPS[pi]);
    end
    nm = m.len();
    if (64 - pre < nm) nm = 64 - pre;
    for (int j = 0; j < 64; j++) lit[j] = (j < nm) ? m[j] : 8'h20;
  endtask

  task automatic model();
    logic [6:0] s;
    logic [7:0] c, o;
    bit ok;
    int w;
    wq.delete();
    m_seed = cmem[0][6:0] ^ 7'h20;
    m_fail = 1'b1;
    m_tap  = 4'hF;
    m_par  = '0;
    for (int p = 0; p < 9; p++) begin
      s = m_seed;
      ok = 1'b1;
      for (int k = 1; k < 10; k++) begin
        s = lstep(s, TAPS[p]);
        if (s != (cmem[k][6:0] ^ 7'h20)) ok = 1'b0;
      end
      if (ok && m_fail) begin
        m_fail = 1'b0;
        m_tap  = 4'(p);
      end
    end
    if (!m_fail) begin
      s = m_seed;
      w = 0;
      for (int i = 0; i < 64; i++) begin
        c = cmem[i];
        if (c[7] != ^c[6:0]) begin
          o = 8'h80;
          m_par++;
        end else o = {1'b0, c[6:0] ^ s};
        if (!(w == 0 && o == 8'h20)) begin
          wq.push_back({8'(w), o});
          m_mem[w] = o;
          w++;
        end
        s = lstep(s, TAPS[m_tap]);
      end
      for (; w < 64; w++) begin
        wq.push_back({8'(w), 8'h20});
        m_mem[w] = 8'h20;
      end
    end
  endtask

  // every DM write must be the next one the model predicts
  logic [15:0] mon_e;
  always @(negedge clk) begin
    if (init && dm_we) begin
      chk("write_pending", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        mon_e = wq.pop_front();
        chk("write_addr_data", {16'd0, dm_waddr, dm_wdata}, {16'd0, mon_e});
      end
    end
  end

  task automatic launch();
    @(negedge clk) req = 1'b0;
    @(negedge clk) req = 1'b1;
  endtask

  // lt/ls/lp < 0 skip that literal pin; lf is the literal fail expectation
  task automatic run_case(input string nm, input int lt, input int ls, input int lf,
                          input int lp, input bit use_lit);
    int t;
    model();
    launch();
    t = 0;
    while (!ack && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_ack"}, 32'(ack), 32'd1);
    chk({nm, "_tap"}, 32'(tap_idx), 32'(m_tap));
    chk({nm, "_seed"}, 32'(seed), 32'(m_seed));
    chk({nm, "_fail"}, 32'(fail), 32'(m_fail));
    chk({nm, "_par"}, 32'(par_err_cnt), 32'(m_par));
    if (lt >= 0) chk({nm, "_tap_lit"}, 32'(tap_idx), 32'(lt));
    if (ls >= 0) chk({nm, "_seed_lit"}, 32'(seed), 32'(ls));
    chk({nm, "_fail_lit"}, 32'(fail), 32'(lf));
    if (lp >= 0) chk({nm, "_par_lit"}, 32'(par_err_cnt), 32'(lp));
    @(negedge clk);
    chk({nm, "_writes_left"}, 32'(wq.size()), 32'd0);
    chk({nm, "_back_idle"}, 32'(ack), 32'd0);
    if (!m_fail)
      for (int j = 0; j < 64; j++) begin
        chk({nm, "_dm_model"}, 32'(pmem[j]), 32'(m_mem[j]));
        if (use_lit) chk({nm, "_dm_lit"}, 32'(pmem[j]), 32'(lit[j]));
      end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ack"}, 32'(ack), 32'd0);
    chk({nm, "_we"}, 32'(dm_we), 32'd0);
    chk({nm, "_fail"}, 32'(fail), 32'd0);
    chk({nm, "_raddr"}, 32'(dm_raddr), 32'd0);
    chk({nm, "_waddr"}, 32'(dm_waddr), 32'd0);
    chk({nm, "_wdata"}, 32'(dm_wdata), 32'd0);
    chk({nm, "_tap"}, 32'(tap_idx), 32'hF);
    chk({nm, "_seed"}, 32'(seed), 32'd0);
    chk({nm, "_par"}, 32'(par_err_cnt), 32'd0);
  endtask

  string msg = "Mr. Watson, come here. I want to see you.";

  initial begin
    int t;
    init = 1'b0;
    req  = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    init = 1'b1;
    @(negedge clk);

    // 1: basic message
    build(msg, 10, 7'h01, 0);
    chk("c1_byte0", 32'(cmem[0]), 32'h21);
    chk("c1_byte1", 32'(cmem[1]), 32'h22);
    run_case("c1", 0, 7'h01, 0, 0, 1'b1);

    // 2: long preamble, every tap pattern
    for (int pi = 0; pi < 9; pi++) begin
      build(msg, 26, 7'h7F, pi);
      run_case($sformatf("c2_p%0d", pi), -1, 7'h7F, 0, 0, 1'b1);
    end

    // 3: single parity error on message char 20
    build(msg, 10, 7'h01, 0);
    cmem[30] = cmem[30] ^ 8'h01;
    lit[20] = 8'h80;
    run_case("c3", 0, 7'h01, 0, 1, 1'b1);

    // 4: all spaces
    build("", 10, 7'h35, 4);
    run_case("c4", 4, 7'h35, 0, 0, 1'b1);

    // 5: corrupted preamble, no pattern fits
    build(msg, 10, 7'h01, 0);
    cmem[5] = 8'h5A;
    run_case("c5", 4'hF, 7'h01, 1, 0, 1'b0);

    // 6: reset mid-decode, then rerun case 1
    build(msg, 10, 7'h01, 0);
    model();
    launch();
    t = 0;
    while (dm_raddr != 8'd84 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("c6_reached_i20", 32'(dm_raddr), 32'd84);
    init = 1'b0;
    @(negedge clk);
    chk_reset("c6_midrun");
    init = 1'b1;
    wq.delete();
    @(negedge clk);
    chk("c6_idle_hold", 32'(dm_raddr), 32'd0);
    run_case("c6_rerun", 0, 7'h01, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
